mac_window_pe: RTL

Parametrised, pipelined multiply-accumulate processing element for the convolution core. It accepts a stream of operand pairs under a valid/ready handshake and accumulates exactly `TAPS` products per window (9 for a 3x3 kernel). It presents each window sum on a registered output with backpressure, then clears itself for the next window without losing a cycle. It is the next-generation replacement for the fixed 8-bit free-running MAC element in the PE array.

---
 rtl/mac_window_pe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mac_window_pe.sv
// mac_window_pe: pipelined unsigned multiply-accumulate element.
// Accepts TAPS operand pairs per window under valid/ready and presents
// each window sum on a registered, backpressured output.
// Optional build macro: MAC_PE_SATURATE_EN clamps result to all-ones on
// overflow; when undefined the result wraps.
module mac_window_pe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAPS       = 9,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned RES_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_WIDTH-1:0]  result,
    output logic                  overflow
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic [CNT_W-1:0]     tap_q, tap_d;
    logic [PROD_W-1:0]    prod_q, prod_d;
    logic                 p_valid_q, p_valid_d;
    logic                 p_last_q, p_last_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [RES_WIDTH-1:0] result_q, result_d;
    logic                 overflow_q, overflow_d;

    logic                 stall;
    logic                 accept;
    logic [ACC_WIDTH-1:0] sum;
    logic                 sum_ovf;
    logic [RES_WIDTH-1:0] sum_res;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign sum      = acc_q + ACC_WIDTH'(prod_q);

    // Bits above the result width only exist when the accumulator is wider.
    if (RES_WIDTH < ACC_WIDTH) begin : g_ovf
        assign sum_ovf = |sum[ACC_WIDTH-1:RES_WIDTH];
    end else begin : g_no_ovf
        assign sum_ovf = 1'b0;
    end

    // Reduce the full window sum to the output width (clamp or wrap).
    always_comb begin
`ifdef MAC_PE_SATURATE_EN
        sum_res = sum_ovf ? '1 : sum[RES_WIDTH-1:0];
`else
        sum_res = sum[RES_WIDTH-1:0];
`endif
    end

    // Stage 1: register the product and tap position on each accept.
    always_comb begin
        tap_d     = tap_q;
        prod_d    = prod_q;
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        if (!stall) begin
            if (accept) begin
                prod_d    = PROD_W'(A) * PROD_W'(B);
                p_valid_d = 1'b1;
                p_last_d  = (tap_q == LAST_TAP);
                tap_d     = (tap_q == LAST_TAP) ? '0 : tap_q + CNT_W'(1);
            end else begin
                p_valid_d = 1'b0;
            end
        end
    end

    // Stage 2: accumulate, and on the last tap hand the sum to the output
    // register while clearing the accumulator so the next window starts clean.
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        if (p_valid_q && !stall && p_last_q) begin
            result_d    = sum_res;
            overflow_d  = sum_ovf;
            out_valid_d = 1'b1;
            acc_d       = '0;
        end else begin
            if (p_valid_q && !stall) begin
                acc_d = sum;
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset discarding any partial window.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q       <= '0;
            prod_q      <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            tap_q       <= tap_d;
            prod_q      <= prod_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule
